// File: rtl/crc_checker.sv
// crc_checker: serial CRC receiver/checker.
// A frame's data bits (LSB first, qualified by Active) go into an LFSR that uses
// the same seed and taps as the transmitter. The CRC bits that follow (LSB first,
// qualified by Valid) are compared one at a time against the LFSR, which is
// shifted out as they arrive. A one-cycle Done pulse reports the result on Error.
// Optional build macro: CRC_ERR_CNT_EN adds a saturating 16-bit err_count output
// that counts failed or aborted frames.
module crc_checker #(
    parameter int                   LFSR_WDTH = 8,
    parameter logic [LFSR_WDTH-1:0] SEED      = 8'hD8,
    parameter logic [LFSR_WDTH-1:0] TAPS      = 8'b01000100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        DATA,
    input  logic        Active,
    input  logic        CRC,
    input  logic        Valid,
    output logic        Busy,
    output logic        Done,
    output logic        Error
`ifdef CRC_ERR_CNT_EN
    ,
    output logic [15:0] err_count
`endif
);

    localparam int CNT_W = $clog2(LFSR_WDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_CHECK,
        S_DONE
    } state_t;

    state_t               state, state_n;
    logic [LFSR_WDTH-1:0] lfsr, lfsr_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic                 flag, flag_n;
    logic                 err_r, err_n;

    // Values produced by absorbing one CRC bit; shared by DATA and CHECK
    logic                 chk_flag;
    logic [CNT_W-1:0]     chk_cnt;
    logic                 chk_last;

    // One LFSR step for a data bit: feedback enters the top bit and the tapped positions
    function automatic logic [LFSR_WDTH-1:0] lfsr_step(input logic [LFSR_WDTH-1:0] cur,
                                                      input logic din);
        logic                 fb;
        logic [LFSR_WDTH-1:0] nxt;
        fb             = cur[0] ^ din;
        nxt            = '0;
        nxt[LFSR_WDTH-1] = fb;
        for (int n = 0; n < LFSR_WDTH - 1; n++) begin
            nxt[n] = cur[n+1] ^ (TAPS[n] & fb);
        end
        return nxt;
    endfunction

    // State, LFSR, bit counter, mismatch flag and result registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
            lfsr  <= SEED;
            cnt   <= '0;
            flag  <= 1'b0;
            err_r <= 1'b0;
        end else begin
            state <= state_n;
            lfsr  <= lfsr_n;
            cnt   <= cnt_n;
            flag  <= flag_n;
            err_r <= err_n;
        end
    end

    // Next-state logic: absorb data, compare CRC bits, detect aborts
    always_comb begin
        state_n  = state;
        lfsr_n   = lfsr;
        cnt_n    = cnt;
        flag_n   = flag;
        err_n    = err_r;
        chk_flag = flag | (CRC ^ lfsr[0]);
        chk_cnt  = cnt + CNT_W'(1);
        chk_last = (chk_cnt == CNT_W'(LFSR_WDTH));

        case (state)
            S_IDLE: begin
                // Valid without a preceding data bit is not a frame
                if (Active) begin
                    lfsr_n  = lfsr_step(lfsr, DATA);
                    err_n   = 1'b0;
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (Active) begin
                    lfsr_n = lfsr_step(lfsr, DATA);
                end else if (Valid) begin
                    // The first CRC bit is compared in the cycle it arrives
                    flag_n  = chk_flag;
                    lfsr_n  = lfsr >> 1;
                    cnt_n   = chk_cnt;
                    state_n = chk_last ? S_DONE : S_CHECK;
                    if (chk_last) begin
                        err_n = chk_flag;
                    end
                end
            end
            S_CHECK: begin
                if (Active || !Valid) begin
                    // New data or a missing CRC bit ends the frame as a failure
                    err_n   = 1'b1;
                    state_n = S_DONE;
                end else begin
                    flag_n = chk_flag;
                    lfsr_n = lfsr >> 1;
                    cnt_n  = chk_cnt;
                    if (chk_last) begin
                        err_n   = chk_flag;
                        state_n = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // Reseed so the next frame starts clean; Active here is ignored
                lfsr_n  = SEED;
                cnt_n   = '0;
                flag_n  = 1'b0;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign Done  = (state == S_DONE);
    assign Busy  = (state == S_DATA) || (state == S_CHECK);
    assign Error = err_r;

`ifdef CRC_ERR_CNT_EN
    // Saturating count of frames that finished with Error set
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_count <= 16'h0000;
        end else if (Done && err_r && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_crc_checker.sv
// Self-checking bench for crc_checker: directed frames from the test plan plus
// randomized frames scored against a behavioural CRC reference model.
module tb_crc_checker;

    localparam int         W    = 8;
    localparam logic [7:0] SEED = 8'hD8;
    // Taps 0x44 plus the fed-back top bit, applied after a right shift
    localparam logic [7:0] POLY = 8'hC4;

    logic clk    = 1'b0;
    logic rst    = 1'b0;
    logic DATA   = 1'b0;
    logic Active = 1'b0;
    logic CRC    = 1'b0;
    logic Valid  = 1'b0;
    logic Busy;
    logic Done;
    logic Error;
`ifdef CRC_ERR_CNT_EN
    logic [15:0] err_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    crc_checker #(
        .LFSR_WDTH(8),
        .SEED     (8'hD8),
        .TAPS     (8'b01000100)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .DATA  (DATA),
        .Active(Active),
        .CRC   (CRC),
        .Valid (Valid),
        .Busy  (Busy),
        .Done  (Done),
        .Error (Error)
`ifdef CRC_ERR_CNT_EN
        ,
        .err_count(err_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_cnt();
`ifdef CRC_ERR_CNT_EN
        chk("err_count", {16'h0, err_count}, exp_cnt);
`endif
    endtask

    // CRC of a bit string (LSB first) computed straight from the shift/feedback rule
    function automatic logic [7:0] ref_crc(input logic [63:0] d, input int len);
        logic [7:0] r;
        r = SEED;
        for (int i = 0; i < len; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ POLY) : (r >> 1);
        end
        return r;
    endfunction

    // Send dlen data bits then clen CRC bits; a short CRC ends by Valid drop or Active
    task automatic run_frame(input logic [63:0] d, input int dlen, input logic [7:0] crc,
                             input int clen, input bit act_abort);
        logic exp_err;
        exp_err = (clen < W) || (crc != ref_crc(d, dlen));
        for (int i = 0; i < dlen; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("busy_data", Busy, 1);
                if (i == 1) chk("error_clr", Error, 0);
                if ($urandom % 4 == 0) begin
                    Active = 1'b0;
                    Valid  = 1'b0;
                    @(negedge clk);
                    chk("busy_gap", Busy, 1);
                end
            end
            Active = 1'b1;
            DATA   = d[i];
            Valid  = 1'($urandom % 2);
            CRC    = 1'($urandom % 2);
        end
        for (int j = 0; j < clen; j++) begin
            @(negedge clk);
            chk("busy_crc", Busy, 1);
            chk("done_early", Done, 0);
            Active = 1'b0;
            Valid  = 1'b1;
            CRC    = crc[j];
            DATA   = 1'($urandom % 2);
        end
        @(negedge clk);
        if (clen < W) begin
            chk("done_early", Done, 0);
            Active = act_abort;
            Valid  = 1'b0;
            @(negedge clk);
        end
        Active = 1'($urandom % 2);
        Valid  = 1'($urandom % 2);
        DATA   = 1'($urandom % 2);
        CRC    = 1'($urandom % 2);
        chk("done", Done, 1);
        chk("error", Error, exp_err);
        chk("busy_done", Busy, 0);
        if (exp_err && exp_cnt < 65535) exp_cnt++;
        @(negedge clk);
        Active = 1'b0;
        Valid  = 1'b0;
        chk("done_pulse", Done, 0);
        chk("busy_idle", Busy, 0);
        chk("error_hold", Error, exp_err);
        chk_cnt();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] d;
        logic [7:0]  good;
        logic [7:0]  crc;
        int          dlen;
        int          clen;
        int          sel;

        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_error", Error, 0);
        chk_cnt();
        rst = 1'b1;

        // Valid while idle is not a frame
        repeat (4) begin
            @(negedge clk);
            Valid = 1'b1;
            CRC   = 1'($urandom % 2);
        end
        @(negedge clk);
        Valid = 1'b0;
        chk("idle_valid_busy", Busy, 0);
        chk("idle_valid_done", Done, 0);
        @(negedge clk);
        chk("idle_valid_done2", Done, 0);

        run_frame(64'h0, 8, 8'h14, 8, 1'b0);
        run_frame(64'h0, 8, 8'h15, 8, 1'b0);
        run_frame(64'h0, 8, 8'h14, 4, 1'b0);

        // Reset in the middle of the CRC phase discards the frame
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            Active = 1'b1;
            DATA   = 1'b0;
        end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            Active = 1'b0;
            Valid  = 1'b1;
            CRC    = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst   = 1'b1;
        Valid = 1'b0;
        exp_cnt = 0;
        chk("midrst_busy", Busy, 0);
        chk("midrst_done", Done, 0);
        chk("midrst_error", Error, 0);
        chk_cnt();
        @(negedge clk);
        chk("midrst_nodone", Done, 0);
        run_frame(64'h0, 8, 8'h14, 8, 1'b0);

        // Back-to-back frames with one idle cycle
        run_frame(64'h0, 8, 8'h14, 8, 1'b0);
        run_frame(64'h0, 8, 8'h14, 8, 1'b0);

        // Three failing frames, then reset clears the count
        run_frame(64'h0, 8, 8'h94, 8, 1'b0);
        run_frame(64'h0, 8, 8'h14, 5, 1'b1);
        run_frame(64'h0, 8, 8'h14, 2, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_cnt = 0;
        chk("rst2_error", Error, 0);
        chk_cnt();

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            d    = {$urandom, $urandom};
            dlen = 1 + int'($urandom % 40);
            good = ref_crc(d, dlen);
            sel  = int'($urandom % 4);
            case (sel)
                0, 1:    crc = good;
                2:       crc = good ^ (8'h01 << ($urandom % 8));
                default: crc = 8'($urandom);
            endcase
            clen = ($urandom % 4 == 0) ? 1 + int'($urandom % 7) : W;
            run_frame(d, dlen, crc, clen, 1'($urandom % 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/crc_checker.md
Name: crc_checker

Overview:
- Serial CRC receiver/checker: the far end of the serial CRC generator link.
- Absorbs a serial data frame (LSB first, qualified by Active) into an LFSR with the same seed and taps as the generator.
- Then absorbs the serial CRC that follows (LSB first, qualified by Valid) and compares it bit by bit against its own LFSR.
- Reports pass/fail with a one-cycle Done pulse.

Parameters:
- LFSR_WDTH, 8, width of the LFSR and of the CRC field.
- SEED, 8'hD8, LFSR value loaded at reset and at the start of every frame.
- TAPS, 8'b01000100, feedback tap mask; bit N set means position N XORs in the feedback.

Ports:
- clk  input  1  clock; all logic on its rising edge.
- rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- DATA  input  1  serial data bit, LSB first, sampled while Active=1.
- Active  input  1  data-phase qualifier.
- CRC  input  1  serial CRC bit, LSB first, sampled while Valid=1.
- Valid  input  1  CRC-phase qualifier.
- Busy  output  1  high from the first data bit until Done.
- Done  output  1  one-cycle pulse when a frame finishes, whether checked or aborted.
- Error  output  1  frame result; meaningful when Done=1 and held until the next frame starts.

Behaviour:
- Reset (rst=0 at a clock edge):
  - LFSR<=SEED, bit counter<=0, state<=IDLE.
  - Busy=0, Done=0, Error=0.
  - Applies mid-frame too: the frame is discarded with no Done pulse.
- LFSR update, per sampled data bit, with fb = LFSR[0]^DATA:
  - LFSR[W-1] <= fb.
  - For N = W-2..0: LFSR[N] <= LFSR[N+1] ^ (TAPS[N] & fb).
- State machine:
  - IDLE: Active=1 -> absorb bit, Busy<=1, Error<=0, go to DATA.
  - DATA: Active=1 -> absorb bit.
    - Active=0 and Valid=1 -> enter CHECK and compare this same cycle's CRC bit.
    - Both 0 -> wait in DATA; the gap length is unbounded.
  - CHECK: each cycle with Valid=1:
    - mismatch flag |= (CRC ^ LFSR[0]).
    - LFSR shifts right with 0 fill; count++.
    - After LFSR_WDTH bits -> DONE.
  - DONE, exactly one cycle:
    - Done=1, Error=mismatch flag, Busy=0.
    - Next state IDLE; LFSR<=SEED, counter and flag cleared.
- Latency: Done is asserted in the cycle after the last CRC bit is sampled.
- Boundary conditions:
  - Valid drops in CHECK before LFSR_WDTH bits: abort; DONE with Error=1.
  - Active=1 during CHECK: abort the same way; that bit is not absorbed as new data.
  - Active and Valid both 1 in DATA: Active has priority; bit treated as data.
  - Valid=1 while IDLE: ignored.
  - Zero-length data frame (Valid with no prior Active): ignored.
  - Active=1 in the DONE cycle: ignored; the bench must leave at least one idle cycle between frames.
  - Data length is not restricted to LFSR_WDTH; any length of 1 or more is accepted.

Optional Feature:
- Macro: CRC_ERR_CNT_EN.
- When defined:
  - Extra output port err_count [15:0].
  - Increments in each DONE cycle with Error=1; saturates at 16'hFFFF.
  - Cleared only by reset.
- When undefined: the port and counter do not exist; behaviour is otherwise identical.

Test Plan:
- Data 8'h00 (8 bits), then CRC 8'h14 sent LSB first (0,0,1,0,1,0,0,0) -> Done pulse one cycle after the 8th CRC bit, Error=0, Busy back to 0.
- Same data, CRC 8'h15 (bit 0 flipped) -> Done=1, Error=1; with CRC_ERR_CNT_EN, err_count=1.
- Data 8'h00, then Valid deasserted after 4 CRC bits -> abort; Done=1, Error=1 on the following cycle.
- rst=0 asserted mid-CHECK -> next cycle Busy=0, Done=0, Error=0. A fresh 8'h00 / 8'h14 frame afterwards passes with Error=0.
- Back-to-back frames: 8'h00/8'h14, one idle cycle, 8'h00/8'h14 -> two Done pulses, both Error=0; shows the LFSR reseeds between frames.
- With CRC_ERR_CNT_EN: drive 3 failing frames -> err_count=3; reset -> err_count=0.
